// File: rtl/v_instr_issue_queue_pkg.sv
// ---------------------------------------------------------------------------
// v_instr_issue_queue_pkg
// Shared types and constants for the vector instruction issue queue.
//   iq_state_t : issue FSM states (idle / executing)
//   iq_entry_t : one queued item, instruction word plus captured rs1 value
//   is_cfg()   : recognises vsetvli / vsetivli / vsetvl
// ---------------------------------------------------------------------------
package v_instr_issue_queue_pkg;

  typedef enum logic {
    IQ_IDLE = 1'b0,
    IQ_EXEC = 1'b1
  } iq_state_t;

  localparam logic [6:0] OPC_OPV  = 7'b1010111;
  localparam logic [2:0] F3_OPCFG = 3'b111;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] xdata;
  } iq_entry_t;

  // Config instructions finish after a single execute cycle and never
  // produce a v_done from the coprocessor.
  function automatic logic is_cfg(input logic [31:0] instr);
    return (instr[6:0] == OPC_OPV) && (instr[14:12] == F3_OPCFG);
  endfunction

endpackage

// File: rtl/v_instr_issue_queue_if.sv
// ---------------------------------------------------------------------------
// v_instr_issue_queue_if
// Dispatch channel from the scalar core into the issue queue.
//   s_instr_valid : scalar core presents an instruction
//   s_instr       : vector instruction word
//   s_xreg_data   : rs1 value captured at dispatch
//   s_instr_ready : queue can accept this cycle
// Modports: master = scalar core, slave = issue queue.
// ---------------------------------------------------------------------------
interface v_instr_issue_queue_if;

  logic        s_instr_valid;
  logic [31:0] s_instr;
  logic [31:0] s_xreg_data;
  logic        s_instr_ready;

  modport master (
    output s_instr_valid,
    output s_instr,
    output s_xreg_data,
    input  s_instr_ready
  );

  modport slave (
    input  s_instr_valid,
    input  s_instr,
    input  s_xreg_data,
    output s_instr_ready
  );

endinterface

// File: rtl/v_instr_issue_queue_fifo.sv
// ---------------------------------------------------------------------------
// v_iq_fifo
// Storage FIFO for the issue queue. The head entry is presented
// combinationally so the issue register can capture it on the pop edge.
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_wdata at the tail (ignored when full)
//   i_pop     : retire the head entry (ignored when empty)
//   o_rdata   : current head entry
//   o_count   : registered occupancy
//   o_empty   : registered, o_count == 0
//   o_full    : registered, o_count == DEPTH
// ---------------------------------------------------------------------------
module v_iq_fifo
  import v_instr_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  iq_entry_t        i_wdata,
  input  logic             i_pop,
  output iq_entry_t        o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  iq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_empty;
  logic             r_full;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_next;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == CNT_W'(DEPTH));
    end
  end

  assign o_count = r_count;
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/v_instr_issue_queue.sv
// ---------------------------------------------------------------------------
// v_instr_issue_queue
// Buffers vector instructions from the scalar core and issues them one at a
// time to the vector coprocessor, holding each stable until it completes.
//   clk, nrst      : clock, asynchronous active-high reset (1 = reset)
//   s_if (slave)   : dispatch handshake, ready = !full
//   op_instr_base  : instruction in execution (0 when idle)
//   xreg_out       : rs1 value paired with op_instr_base
//   v_issue        : pulse on the first cycle of each issued instruction
//   v_done         : coprocessor completion for non-config instructions
//   v_busy         : an instruction is executing
//   q_count/q_empty/q_full : registered FIFO status
//   v_timeout_err  : sticky watchdog error
// Optional build macro: V_IQ_TIMEOUT_EN adds a per-instruction watchdog that
// forces completion after TIMEOUT execute cycles; without it v_timeout_err
// is tied low.
// ---------------------------------------------------------------------------
module v_instr_issue_queue
  import v_instr_issue_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int TIMEOUT = 256
) (
  input  logic                        clk,
  input  logic                        nrst,
  v_instr_issue_queue_if.slave        s_if,
  output logic [31:0]                 op_instr_base,
  output logic [31:0]                 xreg_out,
  output logic                        v_issue,
  input  logic                        v_done,
  output logic                        v_busy,
  output logic [CNT_W-1:0]            q_count,
  output logic                        q_empty,
  output logic                        q_full,
  output logic                        v_timeout_err
);

  iq_state_t   r_state;
  logic [31:0] r_instr;
  logic [31:0] r_xreg;
  logic        r_issue;

  iq_entry_t   w_head;
  iq_entry_t   w_wdata;
  logic        w_push;
  logic        w_pop;
  logic        w_done_ok;
  logic        w_tmo_hit;
  logic        w_complete;

  assign s_if.s_instr_ready = !q_full;
  assign w_push  = s_if.s_instr_valid && !q_full;
  assign w_wdata = {s_if.s_instr, s_if.s_xreg_data};

  v_iq_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (nrst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (q_count),
    .o_empty (q_empty),
    .o_full  (q_full)
  );

  // Config instructions retire after their single execute cycle; v_done is
  // only meaningful for everything else.
  assign w_done_ok  = (r_state == IQ_EXEC) && (is_cfg(r_instr) || v_done);
  assign w_complete = w_done_ok || w_tmo_hit;
  // Pop either to start from idle or back-to-back on the completion edge.
  assign w_pop      = !q_empty && ((r_state == IQ_IDLE) || w_complete);

`ifdef V_IQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  // Counter sits at 0 during the first execute cycle, so the limit is hit on
  // the TIMEOUT-th cycle of execution.
  assign w_tmo_hit = (r_state == IQ_EXEC) && !w_done_ok &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (w_pop) begin
        r_tmo_cnt <= '0;
      end else if (r_state == IQ_EXEC) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
      if (w_tmo_hit) r_tmo_err <= 1'b1;
    end
  end

  assign v_timeout_err = r_tmo_err;
`else
  // TIMEOUT only matters when the watchdog is built in.
  localparam int unused_timeout = TIMEOUT;

  assign w_tmo_hit     = 1'b0;
  assign v_timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state <= IQ_IDLE;
      r_instr <= '0;
      r_xreg  <= '0;
      r_issue <= 1'b0;
    end else begin
      r_issue <= 1'b0;
      if (w_pop) begin
        r_state <= IQ_EXEC;
        r_instr <= w_head.instr;
        r_xreg  <= w_head.xdata;
        r_issue <= 1'b1;
      end else if (w_complete) begin
        // Nothing left to issue: drive zeros while idle.
        r_state <= IQ_IDLE;
        r_instr <= '0;
        r_xreg  <= '0;
      end
    end
  end

  assign op_instr_base = r_instr;
  assign xreg_out      = r_xreg;
  assign v_issue       = r_issue;
  assign v_busy        = (r_state == IQ_EXEC);

endmodule

// File: tb/tb_v_instr_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_v_instr_issue_queue
// Randomised and directed stimulus against a queue-based reference model.
// Accepted instructions go into a scoreboard; a separate monitor pops and
// compares on every v_issue pulse.
// ---------------------------------------------------------------------------
module tb_v_instr_issue_queue;

  localparam int DEPTH      = 4;
  localparam int CNT_W      = $clog2(DEPTH + 1);
  localparam int TB_TIMEOUT = 16;
`ifdef V_IQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [31:0] VSETVLI = 32'h0201_7057;
  localparam logic [31:0] VADD    = 32'h0220_8157;

  logic             clk = 1'b0;
  logic             nrst = 1'b1;
  logic             v_done = 1'b0;
  logic [31:0]      op_instr_base;
  logic [31:0]      xreg_out;
  logic             v_issue;
  logic             v_busy;
  logic [CNT_W-1:0] q_count;
  logic             q_empty;
  logic             q_full;
  logic             v_timeout_err;

  v_instr_issue_queue_if s_if ();

  v_instr_issue_queue #(
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .s_if          (s_if),
    .op_instr_base (op_instr_base),
    .xreg_out      (xreg_out),
    .v_issue       (v_issue),
    .v_done        (v_done),
    .v_busy        (v_busy),
    .q_count       (q_count),
    .q_empty       (q_empty),
    .q_full        (q_full),
    .v_timeout_err (v_timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_issue  = 0;

  // Reference model: waiting entries, the one in execution, and flags.
  logic [63:0] m_q[$];
  logic [63:0] sb_q[$];
  logic [63:0] m_cur  = '0;
  bit          m_busy = 1'b0;
  bit          m_issue = 1'b0;
  bit          m_err  = 1'b0;
  int          m_tcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tb_is_cfg(input logic [31:0] w);
    return (w[6:0] == 7'h57) && (w[14:12] == 3'd7);
  endfunction

  function automatic logic [31:0] rnd_instr(input bit cfg);
    logic [31:0] w;
    w = $urandom;
    if (cfg) begin
      w[6:0]   = 7'h57;
      w[14:12] = 3'b111;
    end else if (tb_is_cfg(w)) begin
      w[12] = 1'b0;
    end
    return w;
  endfunction

  task automatic check_outputs();
    chk("v_busy", v_busy, m_busy);
    chk("v_issue", v_issue, m_issue);
    chk("q_count", q_count, m_q.size());
    chk("q_empty", q_empty, m_q.size() == 0);
    chk("q_full", q_full, m_q.size() == DEPTH);
    chk("s_instr_ready", s_if.s_instr_ready, m_q.size() < DEPTH);
    chk("op_instr_base", op_instr_base, m_cur[63:32]);
    chk("xreg_out", xreg_out, m_cur[31:0]);
    chk("v_timeout_err", v_timeout_err, m_err);
  endtask

  // Called just after a falling edge: check, drive, predict the next rising
  // edge, then wait for the following falling edge.
  task automatic step(input bit val, input logic [31:0] ins, input logic [31:0] xd,
                      input bit done, output bit acc);
    logic [31:0] cur_ins;
    bit          normal;
    bit          tmo;
    check_outputs();
    s_if.s_instr_valid = val;
    s_if.s_instr       = ins;
    s_if.s_xreg_data   = xd;
    v_done             = done;
    acc     = val && (m_q.size() < DEPTH);
    cur_ins = m_cur[63:32];
    normal  = m_busy && (tb_is_cfg(cur_ins) || done);
    tmo     = TMO_EN && m_busy && !normal && (m_tcnt == TB_TIMEOUT - 1);
    if (tmo) m_err = 1'b1;
    m_issue = 1'b0;
    if (!m_busy || normal || tmo) begin
      if (m_q.size() > 0) begin
        m_cur   = m_q.pop_front();
        m_busy  = 1'b1;
        m_issue = 1'b1;
        m_tcnt  = 0;
      end else begin
        m_cur  = '0;
        m_busy = 1'b0;
      end
    end else begin
      m_tcnt++;
    end
    if (acc) begin
      m_q.push_back({ins, xd});
      sb_q.push_back({ins, xd});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit done);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, done, a);
  endtask

  task automatic do_reset();
    #2;
    nrst = 1'b1;
    #1;
    chk("rst_op_instr_base", op_instr_base, 0);
    chk("rst_xreg_out", xreg_out, 0);
    chk("rst_v_busy", v_busy, 0);
    chk("rst_v_issue", v_issue, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_q_empty", q_empty, 1);
    chk("rst_q_full", q_full, 0);
    chk("rst_ready", s_if.s_instr_ready, 1);
    chk("rst_timeout_err", v_timeout_err, 0);
    m_q.delete();
    sb_q.delete();
    m_cur = '0; m_busy = 1'b0; m_issue = 1'b0; m_err = 1'b0; m_tcnt = 0;
    s_if.s_instr_valid = 1'b0;
    v_done = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every issue must present the oldest accepted, unissued entry.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!nrst && v_issue) begin
      n_issue++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_order: got %h with nothing expected", op_instr_base);
      end else begin
        e = sb_q.pop_front();
        chk("issue_instr", op_instr_base, e[63:32]);
        chk("issue_xreg", xreg_out, e[31:0]);
        $display("issue %0d: instr=%h xreg=%h", n_issue, op_instr_base, xreg_out);
      end
    end
  end

  initial begin
    bit          a;
    int          n0;
    logic [31:0] ins;
    s_if.s_instr_valid = 1'b0;
    s_if.s_instr       = '0;
    s_if.s_xreg_data   = '0;
    @(negedge clk);
    do_reset();

    // Config then vadd; vadd completes on a v_done after 5 cycles.
    n0 = n_issue;
    step(1'b1, VSETVLI, 32'h0000_0010, 1'b0, a);
    step(1'b1, VADD, 32'h1234_5678, 1'b0, a);
    idle(4, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    chk("two_issues", n_issue - n0, 2);

    // Fill: one in execution, DEPTH queued, sixth push stalls.
    for (int i = 0; i < 5; i++) step(1'b1, rnd_instr(1'b0), $urandom, 1'b0, a);
    ins = rnd_instr(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, ins, 32'h6666_6666, 1'b0, a);
    a = 1'b0;
    for (int i = 0; i < 10 && !a; i++) step(1'b1, ins, 32'h6666_6666, 1'b1, a);
    chk("sixth_accepted", a, 1);
    idle(10, 1'b1);

    // Push and v_done together with two entries waiting.
    step(1'b1, rnd_instr(1'b0), 32'h0000_0001, 1'b0, a);
    step(1'b1, rnd_instr(1'b0), 32'hDEAD_BEEF, 1'b0, a);
    step(1'b1, rnd_instr(1'b0), 32'h0000_0003, 1'b0, a);
    step(1'b1, rnd_instr(1'b0), 32'h0000_0004, 1'b1, a);
    idle(8, 1'b1);

    // 2*DEPTH+1 back-to-back completions to wrap the pointers.
    for (int i = 0; i < 2 * DEPTH + 1; i++) step(1'b1, rnd_instr(i[0]), $urandom, 1'b1, a);
    idle(12, 1'b1);

    // Withheld v_done: watchdog fires when built in, otherwise it waits.
    step(1'b1, rnd_instr(1'b0), 32'hAAAA_0001, 1'b0, a);
    step(1'b1, rnd_instr(1'b0), 32'hAAAA_0002, 1'b0, a);
    idle(TB_TIMEOUT + 4, 1'b0);
    idle(6, 1'b1);

    // Reset in the middle of execution with three entries waiting.
    for (int i = 0; i < 4; i++) step(1'b1, rnd_instr(1'b0), $urandom, 1'b0, a);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 6, rnd_instr($urandom_range(0, 9) < 3), $urandom,
           $urandom_range(0, 9) < 3, a);
    idle(20, 1'b1);
    chk("scoreboard_drained", sb_q.size(), 0);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/v_instr_issue_queue.md
Name: v_instr_issue_queue

Overview:
Sits directly upstream of the integrated vector coprocessor. It accepts vector instructions and their captured scalar operand (rs1 value) from the base scalar core through a valid/ready handshake, and buffers them in a FIFO. It issues them one at a time, holding op_instr_base and xreg_out stable until the coprocessor signals completion. This decouples the scalar pipeline from multi-cycle vector ops (reduction, slide, lanes, LSU).

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CNT_W, $clog2(DEPTH+1), width of occupancy count.
TIMEOUT, 256, watchdog limit in cycles; used only with V_IQ_TIMEOUT_EN.

Ports:
clk  in  1  rising-edge clock
nrst  in  1  asynchronous, active-high reset (asserted = 1)
s_instr_valid  in  1  scalar core presents an instruction
s_instr  in  32  vector instruction word
s_xreg_data  in  32  scalar rs1 value captured at dispatch
s_instr_ready  out  1  queue can accept; equals !full
op_instr_base  out  32  instruction driven to the coprocessor
xreg_out  out  32  scalar operand paired with op_instr_base
v_issue  out  1  one-cycle pulse on the first cycle a new instruction is driven
v_done  in  1  coprocessor completion pulse for a non-config instruction
v_busy  out  1  an instruction is in execution
q_count  out  CNT_W  FIFO occupancy
q_empty  out  1  q_count == 0
q_full  out  1  q_count == DEPTH
v_timeout_err  out  1  sticky watchdog error; constant 0 without V_IQ_TIMEOUT_EN

Behaviour:
- Reset (nrst=1, asynchronous): pointers and count = 0; state IDLE; op_instr_base = 0, xreg_out = 0, v_issue = 0, v_busy = 0, q_empty = 1, q_full = 0, s_instr_ready = 1, v_timeout_err = 0. Reset during execution drops the in-flight instruction and all queued instructions.
- Push: on an edge where s_instr_valid && s_instr_ready, write {s_instr, s_xreg_data} at wr_ptr. wr_ptr wraps modulo DEPTH.
- Push while full is impossible because ready is low. A pop in the same cycle does not raise ready; ready is purely !full.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Config detect: opcode[6:0] == 7'b1010111 and funct3[14:12] == 3'b111 (vsetvli/vsetivli/vsetvl).
- FSM states:
  - IDLE: outputs op_instr_base = 0 and xreg_out = 0. If !q_empty, pop the head into the issue register, set v_issue = 1, and go to EXEC.
  - EXEC: v_busy = 1, and the issue register is held stable. Completion is either (a) v_done = 1, or (b) the head is config and one EXEC cycle has elapsed; v_done is ignored for config.
  - On completion with !q_empty: pop the next entry on the same edge (back-to-back, v_issue pulses again) and stay in EXEC. With q_empty: go to IDLE.
- v_done in IDLE is ignored. v_done on the same cycle as v_issue counts as completion of that instruction.
- Latency: an instruction accepted at edge k into an empty, idle queue appears on op_instr_base after edge k+1. Minimum issue interval is 1 cycle for config instructions.
- q_count, q_empty and q_full are registered and reflect the state after each edge.

Optional Feature:
V_IQ_TIMEOUT_EN
- Defined: a counter clears on each issue and increments each EXEC cycle. When it reaches TIMEOUT without completion:
  - force completion of the current instruction;
  - set v_timeout_err (sticky until reset);
  - continue with the next entry.
- Undefined: no counter, EXEC waits indefinitely, and v_timeout_err is tied to 0.

Decomposition:
- In v_pkg: iq_state_t enum {IQ_IDLE, IQ_EXEC}; OPC_OPV = 7'b1010111; F3_OPCFG = 3'b111; iq_entry_t packed struct {instr[31:0], xdata[31:0]}.
- One sub-module, v_iq_fifo: parameterised storage array, pointers, count, full/empty, with push/pop strobes.
- The FSM, issue register and watchdog live in the top.

Test Plan:
1. Reset mid-EXEC with 3 entries queued → the next cycle shows op_instr_base = 0, v_busy = 0, q_count = 0, s_instr_ready = 1.
2. Push 32'h0201_7057 (vsetvli) then 32'h0220_8157 (vadd.vv) into an empty queue:
   - vsetvli is issued one cycle after its push and held one cycle;
   - vadd is issued next and held until v_done, pulsed after 5 cycles;
   - v_issue pulses exactly twice.
3. Push 5 instructions with DEPTH=4 while v_done is held 0:
   - 1 instruction is issued, 4 are queued, q_full = 1, ready = 0;
   - the 6th push stalls, with no data loss and no overwrite.
4. Push and v_done on the same cycle with q_count = 2:
   - q_count stays 2;
   - the next entry is issued back-to-back, and xreg_out matches its pushed s_xreg_data (e.g. 32'hDEAD_BEEF).
5. Issue 2×DEPTH+1 instructions in sequence → pointers wrap; issue order equals push order, checked against a scoreboard.
6. (V_IQ_TIMEOUT_EN, TIMEOUT = 16) never assert v_done → at cycle 16 of EXEC:
   - v_timeout_err = 1 and the next entry is issued;
   - the error stays 1 after later normal completions.
